// File: rtl/ccip_intr_pkg.sv
// ---------------------------------------------------------------------------
// ccip_intr_pkg
// Shared types for the CCI-P interrupt request engine.
//  - Minimal CCI-P c1 channel types (Tx request header, Rx response header,
//    request/response type enums) laid out as 80-bit / 28-bit headers.
//  - Interrupt-id vector type and the number of interrupt ids.
//  - build_intr_hdr(): builds an eREQ_INTR header and presents it in the
//    generic memory-request header shape carried on the c1 Tx channel.
// ---------------------------------------------------------------------------
package ccip_intr_pkg;

    localparam int NUM_INTR_IDS  = 4;
    localparam int CCIP_CLDATA_W = 512;

    typedef logic [NUM_INTR_IDS-1:0] t_intr_vec;
    typedef logic [1:0]              t_ccip_intrVecId;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    // Generic c1 Tx request header (80 bits).
    typedef struct packed {
        logic [5:0]   rsvd2;
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        logic [1:0]   cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    // Interrupt view of the same 80 bits; req_type lines up with the
    // memory-header req_type so either view decodes the packet type.
    typedef struct packed {
        logic [11:0]     rsvd1;
        t_ccip_c1_req    req_type;
        logic [61:0]     rsvd0;
        t_ccip_intrVecId id;
    } t_ccip_c1_ReqIntrHdr;

    // Generic c1 Rx response header (28 bits).
    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c1_RspMemHdr;

    // Interrupt response view of the same 28 bits.
    typedef struct packed {
        logic [7:0]      rsvd1;
        t_ccip_c1_rsp    resp_type;
        logic [13:0]     rsvd0;
        t_ccip_intrVecId id;
    } t_ccip_c1_RspIntrHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr       hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    function automatic t_ccip_c1_ReqMemHdr build_intr_hdr(input t_ccip_intrVecId id);
        t_ccip_c1_ReqIntrHdr h;
        h          = '0;
        h.req_type = eREQ_INTR;
        h.id       = id;
        return t_ccip_c1_ReqMemHdr'(h);
    endfunction

endpackage

// File: rtl/ccip_intr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal pointer register.
//  clk        in   clock
//  rst        in   asynchronous active-high reset (pointer returns to 0)
//  req        in   N request lines
//  advance    in   the current grant is being consumed; move the pointer
//  grant      out  one-hot grant (combinational)
//  grant_idx  out  index of the granted line (combinational)
//  any        out  at least one request is present
// The winner is the first requesting line at or after the pointer; when the
// grant is consumed the pointer moves to the line just past the winner.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;
    int               cand;

    // Scan forward from the pointer, wrapping, and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && req[IDX_W'(cand)]) begin
                any                   = 1'b1;
                grant_idx             = IDX_W'(cand);
                grant[IDX_W'(cand)]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/ccip_intr_arb.sv
// ---------------------------------------------------------------------------
// ccip_intr_arb
// Interrupt request engine sitting directly upstream of af2cp_sTxPort.c1.
//  Clk_400        in   clock
//  SoftReset      in   asynchronous active-high reset
//  intr_req       in   one-cycle request pulse per interrupt id
//  usr_c1Tx       in   user c1 write traffic (user already obeys almost-full)
//  c1TxAlmFull    in   c1 Tx almost-full from the FIU
//  cp2af_c1Rx     in   c1 response channel from the FIU
//  af2cp_c1Tx     out  merged c1 Tx to the FIU, registered
//  intr_pending   out  ids requested but not yet issued
//  intr_inflight  out  ids issued whose response has not returned
//  num_issued     out  interrupt packets sent (wraps)
//  num_coalesced  out  requests merged into an already-pending id (wraps)
//  err_unexp_rsp  out  sticky: interrupt response for an id not in flight
// User traffic always wins the slot; interrupts fill idle slots only when
// the FIU is not almost-full, one outstanding interrupt per id.
// ---------------------------------------------------------------------------
module ccip_intr_arb
    import ccip_intr_pkg::*;
#(
    parameter int NUM_IDS = NUM_INTR_IDS,
    parameter int CNT_W   = 32
) (
    input  logic               Clk_400,
    input  logic               SoftReset,
    input  logic [NUM_IDS-1:0] intr_req,
    input  t_if_ccip_c1_Tx     usr_c1Tx,
    input  logic               c1TxAlmFull,
    input  t_if_ccip_c1_Rx     cp2af_c1Rx,
    output t_if_ccip_c1_Tx     af2cp_c1Tx,
    output logic [NUM_IDS-1:0] intr_pending,
    output logic [NUM_IDS-1:0] intr_inflight,
    output logic [CNT_W-1:0]   num_issued,
    output logic [CNT_W-1:0]   num_coalesced,
    output logic               err_unexp_rsp
);

    localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

    logic [NUM_IDS-1:0]  eligible;
    logic [NUM_IDS-1:0]  arb_grant;
    logic [IDX_W-1:0]    winner;
    logic                arb_any;
    logic                grant;
    logic [NUM_IDS-1:0]  grant_mask;

    t_ccip_c1_RspIntrHdr rsp_hdr;
    logic                rsp_is_intr;
    logic [NUM_IDS-1:0]  rsp_vec;
    logic                unused_rsp_bits;

    logic [NUM_IDS-1:0]  pending_next;
    logic [NUM_IDS-1:0]  inflight_next;
    logic [NUM_IDS-1:0]  coalesce_vec;
    logic [CNT_W-1:0]    coalesce_cnt;
    logic                err_next;

    // Eligibility uses the registered inflight bits, so an id whose response
    // arrives this cycle is only considered on the following cycle.
    assign eligible = intr_pending & ~intr_inflight;
    assign grant    = !usr_c1Tx.valid && !c1TxAlmFull && arb_any;

    rr_arbiter #(
        .N (NUM_IDS)
    ) u_rr (
        .clk       (Clk_400),
        .rst       (SoftReset),
        .req       (eligible),
        .advance   (grant),
        .grant     (arb_grant),
        .grant_idx (winner),
        .any       (arb_any)
    );

    assign rsp_hdr         = t_ccip_c1_RspIntrHdr'(cp2af_c1Rx.hdr);
    assign rsp_is_intr     = cp2af_c1Rx.rspValid && (rsp_hdr.resp_type == eRSP_INTR);
    assign unused_rsp_bits = ^{rsp_hdr.rsvd1, rsp_hdr.rsvd0};

    // Per-id state update. A request that lands on the id being granted
    // re-arms pending without counting as a coalesce; a response only clears
    // an id that is genuinely in flight, otherwise it flags an error.
    always_comb begin
        grant_mask    = grant ? arb_grant : '0;
        rsp_vec       = '0;
        if (rsp_is_intr) begin
            rsp_vec[rsp_hdr.id] = 1'b1;
        end
        coalesce_vec  = intr_req & intr_pending & ~grant_mask;
        pending_next  = (intr_pending & ~grant_mask) | intr_req;
        inflight_next = (intr_inflight & ~(rsp_vec & intr_inflight)) | grant_mask;
        err_next      = err_unexp_rsp | (|(rsp_vec & ~intr_inflight));
        coalesce_cnt  = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            coalesce_cnt = coalesce_cnt + CNT_W'(coalesce_vec[i]);
        end
    end

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            intr_pending  <= '0;
            intr_inflight <= '0;
            num_issued    <= '0;
            num_coalesced <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            intr_pending  <= pending_next;
            intr_inflight <= inflight_next;
            err_unexp_rsp <= err_next;
            num_coalesced <= num_coalesced + coalesce_cnt;
            if (grant) begin
                num_issued <= num_issued + CNT_W'(1);
            end
        end
    end

    // Registered output mux: user traffic, else interrupt, else an all-zero
    // idle slot so stale user hdr/data never leak onto the FIU bus.
    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            af2cp_c1Tx <= '0;
        end else if (usr_c1Tx.valid) begin
            af2cp_c1Tx <= usr_c1Tx;
        end else if (grant) begin
            af2cp_c1Tx.hdr   <= build_intr_hdr(t_ccip_intrVecId'(winner));
            af2cp_c1Tx.data  <= '0;
            af2cp_c1Tx.valid <= 1'b1;
        end else begin
            af2cp_c1Tx <= '0;
        end
    end

endmodule

// File: tb/tb_ccip_intr_arb.sv
// ---------------------------------------------------------------------------
// tb_ccip_intr_arb
// Self-checking bench for ccip_intr_arb. A behavioural model of the
// pending/inflight bookkeeping predicts every packet the DUT should send and
// queues it; a monitor pops and compares each packet the DUT presents and
// compares the status outputs against the model every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccip_intr_arb;
    import ccip_intr_pkg::*;

    logic           Clk_400 = 1'b0;
    logic           SoftReset;
    logic [3:0]     intr_req;
    t_if_ccip_c1_Tx usr_c1Tx;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx cp2af_c1Rx;
    t_if_ccip_c1_Tx af2cp_c1Tx;
    logic [3:0]     intr_pending;
    logic [3:0]     intr_inflight;
    logic [31:0]    num_issued;
    logic [31:0]    num_coalesced;
    logic           err_unexp_rsp;

    ccip_intr_arb #(
        .NUM_IDS (4),
        .CNT_W   (32)
    ) dut (
        .Clk_400       (Clk_400),
        .SoftReset     (SoftReset),
        .intr_req      (intr_req),
        .usr_c1Tx      (usr_c1Tx),
        .c1TxAlmFull   (c1TxAlmFull),
        .cp2af_c1Rx    (cp2af_c1Rx),
        .af2cp_c1Tx    (af2cp_c1Tx),
        .intr_pending  (intr_pending),
        .intr_inflight (intr_inflight),
        .num_issued    (num_issued),
        .num_coalesced (num_coalesced),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 Clk_400 = ~Clk_400;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_pend[4];
    bit          m_infl[4];
    int          m_ptr;
    logic [31:0] m_issued;
    logic [31:0] m_coal;
    bit          m_err;
    t_if_ccip_c1_Tx exp_q[$];
    bit          mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] to_vec(input bit a[4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic t_if_ccip_c1_Tx intr_pkt(input int id);
        t_if_ccip_c1_Tx      p;
        t_ccip_c1_ReqIntrHdr h;
        h          = '0;
        h.req_type = eREQ_INTR;
        h.id       = 2'(id);
        p.hdr      = t_ccip_c1_ReqMemHdr'(h);
        p.data     = '0;
        p.valid    = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_infl[i] = 1'b0;
        end
        m_ptr    = 0;
        m_issued = '0;
        m_coal   = '0;
        m_err    = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        intr_req           = '0;
        usr_c1Tx           = '0;
        c1TxAlmFull        = 1'b0;
        cp2af_c1Rx         = '0;
    endtask

    // One clock of stimulus: drive at the falling edge and step the model
    // with the same inputs the DUT will sample at the next rising edge.
    task automatic applyStimulus(input logic [3:0] req, input bit uv, input bit af,
                                 input bit rv, input t_ccip_c1_rsp rtype, input logic [1:0] rid);
        t_if_ccip_c1_Tx      up;
        t_ccip_c1_RspIntrHdr rh;
        bit                  elig[4];
        bit                  g;
        int                  w;
        int                  c;
        @(negedge Clk_400);
        up.hdr = t_ccip_c1_ReqMemHdr'({$urandom, $urandom, 16'($urandom)});
        for (int i = 0; i < 16; i++) up.data[i*32 +: 32] = $urandom;
        up.valid     = uv;
        intr_req     = req;
        usr_c1Tx     = up;
        c1TxAlmFull  = af;
        rh           = '0;
        rh.resp_type = rtype;
        rh.id        = rid;
        cp2af_c1Rx.hdr      = t_ccip_c1_RspMemHdr'(rh);
        cp2af_c1Rx.rspValid = rv;

        for (int i = 0; i < 4; i++) elig[i] = m_pend[i] && !m_infl[i];
        g = 1'b0;
        w = 0;
        if (!uv && !af) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!g && elig[c]) begin
                    g = 1'b1;
                    w = c;
                end
            end
        end
        if (uv) exp_q.push_back(up);
        else if (g) exp_q.push_back(intr_pkt(w));
        if (rv && rtype == eRSP_INTR) begin
            if (m_infl[rid]) m_infl[rid] = 1'b0;
            else m_err = 1'b1;
        end
        for (int i = 0; i < 4; i++)
            if (req[i] && m_pend[i] && !(g && w == i)) m_coal = m_coal + 1;
        if (g) begin
            m_pend[w] = 1'b0;
            m_infl[w] = 1'b1;
            m_issued  = m_issued + 1;
            m_ptr     = (w + 1) % 4;
        end
        for (int i = 0; i < 4; i++) if (req[i]) m_pend[i] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 0, 0, 0, eRSP_WRLINE, 2'd0);
    endtask

    task automatic respond(input logic [1:0] id);
        applyStimulus(4'b0000, 0, 0, 1, eRSP_INTR, id);
    endtask

    // Asynchronous reset assertion away from any clock edge; outputs must
    // clear at once, before the next rising edge.
    task automatic doReset(input string tag);
        @(negedge Clk_400);
        #2;
        SoftReset = 1'b1;
        #1;
        checkOutput({tag, "_valid"},    64'(af2cp_c1Tx.valid), 64'd0);
        checkOutput({tag, "_hdr"},      64'(|af2cp_c1Tx.hdr),  64'd0);
        checkOutput({tag, "_pending"},  64'(intr_pending),     64'd0);
        checkOutput({tag, "_inflight"}, 64'(intr_inflight),    64'd0);
        checkOutput({tag, "_issued"},   64'(num_issued),       64'd0);
        checkOutput({tag, "_coal"},     64'(num_coalesced),    64'd0);
        checkOutput({tag, "_err"},      64'(err_unexp_rsp),    64'd0);
        model_reset();
        drive_idle();
        @(negedge Clk_400);
        #2;
        SoftReset = 1'b0;
    endtask

    // Monitor: pop and compare every packet the DUT presents; track status.
    initial begin
        t_if_ccip_c1_Tx p;
        forever begin
            @(posedge Clk_400);
            #1;
            if (mon_en) begin
                if (af2cp_c1Tx.valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL pkt_unexpected: got hdr=%h expected no packet", af2cp_c1Tx.hdr);
                    end else begin
                        p = exp_q.pop_front();
                        if (af2cp_c1Tx !== p) begin
                            errors++;
                            $display("[TB] FAIL pkt: got hdr=%h valid=%b expected hdr=%h valid=%b data_match=%0d",
                                     af2cp_c1Tx.hdr, af2cp_c1Tx.valid, p.hdr, p.valid,
                                     af2cp_c1Tx.data === p.data);
                        end
                    end
                end
                checkOutput("pending",   64'(intr_pending),  64'(to_vec(m_pend)));
                checkOutput("inflight",  64'(intr_inflight), 64'(to_vec(m_infl)));
                checkOutput("issued",    64'(num_issued),    64'(m_issued));
                checkOutput("coalesced", 64'(num_coalesced), 64'(m_coal));
                checkOutput("err",       64'(err_unexp_rsp), 64'(m_err));
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        t_ccip_c1_ReqIntrHdr ih;
        logic [3:0] req;
        bit uv, af, rv;
        t_ccip_c1_rsp rt;
        logic [1:0] rid;
        int n_infl;

        SoftReset = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge Clk_400);
        doReset("rst0");
        mon_en = 1'b1;

        // T1 basic
        applyStimulus(4'b0100, 0, 0, 0, eRSP_WRLINE, 2'd0);
        idle(1);
        @(posedge Clk_400);
        #2;
        ih = t_ccip_c1_ReqIntrHdr'(af2cp_c1Tx.hdr);
        checkOutput("t1_valid",    64'(af2cp_c1Tx.valid), 64'd1);
        checkOutput("t1_id",       64'(ih.id),            64'd2);
        checkOutput("t1_type",     64'(ih.req_type),      64'(eREQ_INTR));
        checkOutput("t1_inflight", 64'(intr_inflight),    64'b0100);
        checkOutput("t1_issued",   64'(num_issued),       64'd1);
        respond(2'd2);
        @(posedge Clk_400);
        #2;
        checkOutput("t1_rsp_inflight", 64'(intr_inflight), 64'd0);

        // T2 round-robin from a fresh pointer
        doReset("rst_t2");
        applyStimulus(4'b1111, 0, 0, 0, eRSP_WRLINE, 2'd0);
        idle(4);
        @(posedge Clk_400);
        #2;
        checkOutput("t2_issued",   64'(num_issued),    64'd4);
        checkOutput("t2_inflight", 64'(intr_inflight), 64'hf);
        for (int i = 0; i < 4; i++) respond(2'(i));

        // T3 user priority then almost-full, id 1 pending throughout
        applyStimulus(4'b0010, 1, 0, 0, eRSP_WRLINE, 2'd0);
        applyStimulus(4'b0000, 1, 0, 0, eRSP_WRLINE, 2'd0);
        applyStimulus(4'b0000, 1, 0, 0, eRSP_WRLINE, 2'd0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 0, 1, 0, eRSP_WRLINE, 2'd0);
        idle(1);
        @(posedge Clk_400);
        #2;
        ih = t_ccip_c1_ReqIntrHdr'(af2cp_c1Tx.hdr);
        checkOutput("t3_valid", 64'(af2cp_c1Tx.valid), 64'd1);
        checkOutput("t3_id",    64'(ih.id),            64'd1);
        respond(2'd1);

        // T4 coalesce while pending, re-arm while inflight
        for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1, 0, 0, eRSP_WRLINE, 2'd0);
        idle(1);
        @(posedge Clk_400);
        #2;
        checkOutput("t4_coalesced", 64'(num_coalesced), 64'd2);
        applyStimulus(4'b0001, 0, 0, 0, eRSP_WRLINE, 2'd0);
        idle(3);
        respond(2'd0);
        idle(2);
        respond(2'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            req = 4'($urandom & $urandom);
            uv  = ($urandom_range(0, 3) == 0);
            af  = ($urandom_range(0, 7) == 0);
            rv  = 1'b0;
            rt  = eRSP_WRLINE;
            rid = 2'($urandom);
            n_infl = 0;
            for (int i = 0; i < 4; i++) n_infl += m_infl[i];
            if (n_infl > 0 && $urandom_range(0, 1) == 1) begin
                do rid = 2'($urandom); while (!m_infl[rid]);
                rv = 1'b1;
                rt = eRSP_INTR;
            end else if ($urandom_range(0, 15) == 0) begin
                rv = 1'b1;
                rt = eRSP_INTR;
            end else if ($urandom_range(0, 7) == 0) begin
                rv = 1'b1;
            end
            applyStimulus(req, uv, af, rv, rt, rid);
        end
        idle(4);

        // T5 errors
        doReset("rst_t5");
        applyStimulus(4'b0000, 0, 0, 1, eRSP_WRLINE, 2'd3);
        @(posedge Clk_400);
        #2;
        checkOutput("t5_wrline_err", 64'(err_unexp_rsp), 64'd0);
        respond(2'd3);
        idle(2);
        @(posedge Clk_400);
        #2;
        checkOutput("t5_err_sticky", 64'(err_unexp_rsp), 64'd1);

        // T6 reset mid-stream with two ids inflight
        doReset("rst_t5b");
        applyStimulus(4'b0011, 0, 0, 0, eRSP_WRLINE, 2'd0);
        idle(3);
        @(posedge Clk_400);
        #2;
        checkOutput("t6_pre_inflight", 64'(intr_inflight), 64'b0011);
        doReset("rst_t6");
        applyStimulus(4'b1000, 0, 0, 0, eRSP_WRLINE, 2'd0);
        idle(1);
        @(posedge Clk_400);
        #2;
        ih = t_ccip_c1_ReqIntrHdr'(af2cp_c1Tx.hdr);
        checkOutput("t6_id", 64'(ih.id), 64'd3);
        respond(2'd0);
        idle(3);

        @(posedge Clk_400);
        #2;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
